// File: rtl/mem_subsystem.sv
// Memory-side stage: MAR/MDR registers in front of an internal word RAM.
// Each read or write takes MEM_LAT edges and ends with a one-cycle Mem_done pulse.
module mem_subsystem #(
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [31:0]       BusMuxIn_MDR,
  output logic [ADDR_W-1:0] MAR_q,
  output logic              Mem_busy,
  output logic              Mem_done,
  output logic              Mem_err
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_we;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Read && Write) begin
          // Conflicting request leaves every register untouched.
          err_d = 1'b1;
        end else begin
          if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr_d = BusMuxOut;
          // Access latches the pre-edge MAR/MDR, not this edge's loads.
          if (Read) begin
            addr_d  = mar_q;
            cnt_d   = LAT_M1;
            state_d = RD;
            busy_d  = 1'b1;
          end else if (Write) begin
            addr_d  = mar_q;
            wdata_d = mdr_q;
            cnt_d   = LAT_M1;
            state_d = WR;
            busy_d  = 1'b1;
          end
        end
      end
      RD, WR: begin
        if (cnt_q == 4'd0) begin
          if (state_q == RD) mdr_d = mem[addr_q];
          else               mem_we = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; an async clr drops state_q to IDLE so a pending write never fires.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign BusMuxIn_MDR = mdr_q;
  assign MAR_q        = mar_q;
  assign Mem_busy     = busy_q;
  assign Mem_done     = done_q;
  assign Mem_err      = err_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem at MEM_LAT=2: write/read, truncation,
// illegal request, busy-ignore, same-edge load with access, reset mid-write.
module tb_mem_subsystem;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic        MARin = 1'b0;
  logic        MDRin = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] BusMuxIn_MDR;
  logic [8:0]  MAR_q;
  logic        Mem_busy;
  logic        Mem_done;
  logic        Mem_err;

  int checks = 0;
  int failures = 0;

  mem_subsystem #(.ADDR_W(9), .DEPTH(512), .MEM_LAT(2)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .BusMuxIn_MDR(BusMuxIn_MDR), .MAR_q(MAR_q),
    .Mem_busy(Mem_busy), .Mem_done(Mem_done), .Mem_err(Mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [31:0] v);
    BusMuxOut = v; MARin = 1'b1; tick(); MARin = 1'b0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    BusMuxOut = v; MDRin = 1'b1; tick(); MDRin = 1'b0;
  endtask

  // Issues a request at E0 and checks busy/done through E3.
  task automatic access(input string tag, input logic rd, input logic [31:0] exp_mdr);
    Read = rd; Write = ~rd; tick(); Read = 1'b0; Write = 1'b0;
    check({tag, "_busy_e0"}, 32'(Mem_busy), 32'd1);
    check({tag, "_done_e0"}, 32'(Mem_done), 32'd0);
    tick();
    check({tag, "_busy_e1"}, 32'(Mem_busy), 32'd1);
    check({tag, "_done_e1"}, 32'(Mem_done), 32'd0);
    tick();
    check({tag, "_busy_e2"}, 32'(Mem_busy), 32'd0);
    check({tag, "_done_e2"}, 32'(Mem_done), 32'd1);
    check({tag, "_mdr_e2"}, BusMuxIn_MDR, exp_mdr);
    tick();
    check({tag, "_done_e3"}, 32'(Mem_done), 32'd0);
  endtask

  initial begin
    #1 clr = 1'b1;
    #1;
    check("rst_mar", 32'(MAR_q), 32'd0);
    check("rst_mdr", BusMuxIn_MDR, 32'd0);
    check("rst_busy", 32'(Mem_busy), 32'd0);
    check("rst_done", 32'(Mem_done), 32'd0);
    check("rst_err", 32'(Mem_err), 32'd0);
    @(negedge clk) clr = 1'b0;

    // Write DEADBEEF to address 5, then read it back.
    load_mar(32'h0000_0005);
    check("mar_load", 32'(MAR_q), 32'd5);
    load_mdr(32'hDEAD_BEEF);
    check("mdr_load", BusMuxIn_MDR, 32'hDEAD_BEEF);
    access("wr5", 1'b0, 32'hDEAD_BEEF);
    load_mdr(32'h0);
    check("mdr_clear", BusMuxIn_MDR, 32'h0);
    Read = 1'b1; tick(); Read = 1'b0;
    tick();
    check("rd5_mdr_before_done", BusMuxIn_MDR, 32'h0);
    tick();
    check("rd5_done", 32'(Mem_done), 32'd1);
    check("rd5_mdr", BusMuxIn_MDR, 32'hDEAD_BEEF);
    tick();
    check("rd5_done_off", 32'(Mem_done), 32'd0);

    // Illegal request with MDR=0: nothing changes, Mem_err pulses.
    load_mdr(32'h0);
    Read = 1'b1; Write = 1'b1; tick(); Read = 1'b0; Write = 1'b0;
    check("err_pulse", 32'(Mem_err), 32'd1);
    check("err_busy", 32'(Mem_busy), 32'd0);
    check("err_done", 32'(Mem_done), 32'd0);
    check("err_mdr", BusMuxIn_MDR, 32'h0);
    tick();
    check("err_off", 32'(Mem_err), 32'd0);
    check("err_busy_after", 32'(Mem_busy), 32'd0);

    // Truncation plus busy-ignore during the read of address 5.
    load_mar(32'h0000_0205);
    check("trunc_mar", 32'(MAR_q), 32'h005);
    Read = 1'b1; tick(); Read = 1'b0;
    BusMuxOut = 32'h9; MARin = 1'b1; tick(); MARin = 1'b0;
    check("busy_mar_hold", 32'(MAR_q), 32'd5);
    BusMuxOut = 32'h1234; MDRin = 1'b1; tick(); MDRin = 1'b0;
    check("busy_done", 32'(Mem_done), 32'd1);
    check("busy_mdr_rd_wins", BusMuxIn_MDR, 32'hDEAD_BEEF);
    check("busy_mar_hold2", 32'(MAR_q), 32'd5);
    tick();

    // MDRin on the same edge as Write: RAM[7] gets the old MDR.
    load_mar(32'h7);
    load_mdr(32'h1111_1111);
    BusMuxOut = 32'h2222_2222; MDRin = 1'b1; Write = 1'b1; tick();
    MDRin = 1'b0; Write = 1'b0;
    check("coinc_mdr_new", BusMuxIn_MDR, 32'h2222_2222);
    check("coinc_busy", 32'(Mem_busy), 32'd1);
    tick(); tick();
    check("coinc_done", 32'(Mem_done), 32'd1);
    tick();
    access("rd7_old", 1'b1, 32'h1111_1111);

    // Reset one cycle into a write of CAFEF00D to address 7.
    load_mdr(32'hCAFE_F00D);
    Write = 1'b1; tick(); Write = 1'b0;
    check("rw_busy", 32'(Mem_busy), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("rw_async_busy", 32'(Mem_busy), 32'd0);
    check("rw_async_mar", 32'(MAR_q), 32'd0);
    check("rw_async_mdr", BusMuxIn_MDR, 32'd0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_no_done", 32'(Mem_done), 32'd0);
      tick();
    end
    load_mar(32'h7);
    access("rd7_after_rst", 1'b1, 32'h1111_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_subsystem.md
Name: mem_subsystem

Overview:
- Memory-side stage downstream of the register file and bus mux.
- Latches an address from the CPU bus into MAR, with R0 or zero supplied on the bus for base addressing.
- Holds read/write data in MDR and performs multi-cycle accesses to an internal synchronous word RAM.
- Drives MDR back onto the bus-mux input and signals completion to the control unit with a one-cycle done pulse.

Parameters:
ADDR_W, 9, MAR width / RAM address bits
DEPTH, 512, RAM words (must equal 2**ADDR_W)
MEM_LAT, 2, clock edges from request acceptance to completion (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
BusMuxOut  input  32  CPU bus value
MARin  input  1  load MAR from BusMuxOut[ADDR_W-1:0]
MDRin  input  1  load MDR from BusMuxOut
Read  input  1  start RAM read at MAR into MDR
Write  input  1  start RAM write of MDR to MAR
BusMuxIn_MDR  output  32  current MDR contents
MAR_q  output  ADDR_W  current MAR contents
Mem_busy  output  1  access in progress
Mem_done  output  1  one-cycle completion pulse
Mem_err  output  1  one-cycle pulse: Read and Write both sampled high in IDLE

Behaviour:
- Reset (clr=1, async):
  - MAR=0, MDR=0, state=IDLE, counter=0.
  - Mem_busy=0, Mem_done=0, Mem_err=0.
  - RAM contents not cleared.
  - Reset mid-access aborts the access: a pending write never commits, and a pending read never updates MDR.
- States: IDLE, RD, WR.
- IDLE, per rising edge; priority is top item first:
  - Read=1 and Write=1: no access, no register change, Mem_err=1 for the following cycle.
  - Read=1: capture addr=MAR; counter=MEM_LAT-1; go RD; Mem_busy=1.
  - Write=1: capture addr=MAR and wdata=MDR; counter=MEM_LAT-1; go WR; Mem_busy=1.
  - MARin and MDRin are honoured in IDLE on the same edge, independently of each other.
  - When MARin or MDRin coincides with Read or Write, the access uses the values held before that edge, i.e. the old MAR/MDR.
- RD/WR:
  - Counter decrements each edge while non-zero.
  - On the edge where counter==0:
    - RD: MDR <= RAM[addr].
    - WR: RAM[addr] <= wdata.
  - On that same edge: state=IDLE, Mem_busy=0, Mem_done=1 for exactly one cycle.
  - MEM_LAT=1: completes on the first edge after acceptance.
- Timing: request sampled at edge E0 → Mem_busy high from E0 to E(MEM_LAT) → MDR or RAM updated at E(MEM_LAT) → Mem_done high from E(MEM_LAT) to E(MEM_LAT+1).
- Back-to-back: a new Read/Write sampled at E(MEM_LAT+1) is accepted; Mem_done and IDLE sampling overlap legally.
- While busy:
  - Read, Write, MARin and MDRin are ignored.
  - MAR/MDR hold their values.
  - Any MDRin is lost and the read result wins.
- Address width: MAR takes BusMuxOut[ADDR_W-1:0]; upper bits are discarded, with no range error.
- Mem_done and Mem_err are never high simultaneously.
- BusMuxIn_MDR and MAR_q are direct register outputs; no combinational path from inputs.

Test Plan:
- Reset: assert clr asynchronously between edges with MAR/MDR non-zero → MAR_q=0, BusMuxIn_MDR=0, Mem_busy=0 immediately, with no clock needed.
- Write then read, MEM_LAT=2:
  - Sequence: MARin with bus 0x00000005; MDRin with 0xDEADBEEF; Write pulse; MDRin with 0x0; Read pulse.
  - Expected: Mem_busy high 2 cycles each access; Mem_done one cycle each; BusMuxIn_MDR=0xDEADBEEF exactly at read completion edge.
- Truncation: MARin with bus 0x00000205 → MAR_q=0x005; a read returns the word written at address 5.
- Illegal request: Read=1 and Write=1 together in IDLE → Mem_err pulses one cycle; Mem_busy stays 0; RAM and MDR unchanged.
- Busy-ignore: during a read of address 5, assert MARin with bus 0x9 and MDRin with 0x1234 → MAR_q stays 5; MDR=0xDEADBEEF at completion.
- Reset mid-write: Write with MDR=0xCAFEF00D to address 7, pulse clr one cycle after acceptance → later read of address 7 returns its prior value; no Mem_done observed.
